// File: rtl/ls_decode_queue.sv
// ls_decode_queue: decodes RV32 load/store lanes, compacts them into a circular queue, issues one per cycle to the LSU
//  ports: clk, rst_n (async active-low), flush_i; per-lane ins_valid_i/ins_i/ins_tag_i; in_ready_o, ls_mask_o;
//         LSU side lsq_valid_o/lsq_ready_i/lsq_type_o/lsq_ins_o/lsq_tag_o; count_o occupancy
module ls_decode_queue #(
  parameter int INS_WIDTH = 32,
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [NUM_LANES-1:0]           ins_valid_i,
  input  logic [NUM_LANES*INS_WIDTH-1:0] ins_i,
  input  logic [NUM_LANES*TAG_W-1:0]     ins_tag_i,
  output logic                           in_ready_o,
  output logic [NUM_LANES-1:0]           ls_mask_o,
  output logic                           lsq_valid_o,
  input  logic                           lsq_ready_i,
  output logic [3:0]                     lsq_type_o,
  output logic [INS_WIDTH-1:0]           lsq_ins_o,
  output logic [TAG_W-1:0]               lsq_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [3:0]           type_l   [NUM_LANES];
  logic [CW-1:0]        offs     [NUM_LANES];
  logic [3:0]           mem_type [DEPTH];
  logic [INS_WIDTH-1:0] mem_ins  [DEPTH];
  logic [TAG_W-1:0]     mem_tag  [DEPTH];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count, n;
  logic                 enq, deq;
  // offs[k] is the number of mem ops in older lanes, giving each lane its compacted slot
  always_comb begin
    logic [6:0] op;
    logic [2:0] f3;
    logic       ld, st;
    op = '0;
    f3 = '0;
    ld = 1'b0;
    st = 1'b0;
    n = '0;
    ls_mask_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      op = ins_i[k*INS_WIDTH +: 7];
      f3 = ins_i[k*INS_WIDTH+12 +: 3];
      ld = (op == 7'b0000011) && (f3 != 3'b011) && (f3 < 3'b110);
      st = (op == 7'b0100011) && (f3 < 3'b011);
      ls_mask_o[k] = ins_valid_i[k] & (ld | st);
      type_l[k] = {st, f3};
      offs[k] = n;
      n = n + CW'(ls_mask_o[k]);
    end
  end
  assign in_ready_o  = count <= CW'(DEPTH - NUM_LANES);
  assign lsq_valid_o = count != '0;
  assign enq         = in_ready_o & |ls_mask_o & ~flush_i;
  assign deq         = lsq_valid_o & lsq_ready_i & ~flush_i;
  assign lsq_type_o  = mem_type[head];
  assign lsq_ins_o   = mem_ins[head];
  assign lsq_tag_o   = mem_tag[head];
  assign count_o     = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(n);
      if (deq) head <= head + PW'(1);
      count <= count + (enq ? n : '0) - CW'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (ls_mask_o[k]) begin
          mem_type[tail + PW'(offs[k])] <= type_l[k];
          mem_ins[tail + PW'(offs[k])]  <= ins_i[k*INS_WIDTH +: INS_WIDTH];
          mem_tag[tail + PW'(offs[k])]  <= ins_tag_i[k*TAG_W +: TAG_W];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) assert (count <= CW'(DEPTH));
  end
endmodule

// File: tb/tb_ls_decode_queue.sv
// tb_ls_decode_queue: scoreboard bench for ls_decode_queue (NUM_LANES=2, DEPTH=8)
module tb_ls_decode_queue;
  typedef struct packed {logic [3:0] t; logic [31:0] ins; logic [4:0] tag;} ent_t;
  logic        clk = 0, rst_n = 0, flush = 0, lsq_ready = 0;
  logic [1:0]  ins_valid = '0;
  logic [63:0] ins = '0;
  logic [9:0]  tag = '0;
  logic        in_ready, lsq_valid;
  logic [1:0]  ls_mask;
  logic [3:0]  lsq_type;
  logic [31:0] lsq_ins;
  logic [4:0]  lsq_tag;
  logic [3:0]  count;
  ent_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  ls_decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .ins_valid_i(ins_valid), .ins_i(ins),
    .ins_tag_i(tag), .in_ready_o(in_ready), .ls_mask_o(ls_mask), .lsq_valid_o(lsq_valid),
    .lsq_ready_i(lsq_ready), .lsq_type_o(lsq_type), .lsq_ins_o(lsq_ins), .lsq_tag_o(lsq_tag),
    .count_o(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {7'd0, 5'd2, 5'd3, f3, 5'd1, op};
  endfunction
  // {is_mem, type} straight from the RV32 load/store encoding table
  function automatic logic [4:0] dec(input logic [31:0] i);
    case ({i[14:12], i[6:0]})
      {3'd0, 7'h03}: return 5'b1_0000;
      {3'd1, 7'h03}: return 5'b1_0001;
      {3'd2, 7'h03}: return 5'b1_0010;
      {3'd4, 7'h03}: return 5'b1_0100;
      {3'd5, 7'h03}: return 5'b1_0101;
      {3'd0, 7'h23}: return 5'b1_1000;
      {3'd1, 7'h23}: return 5'b1_1001;
      {3'd2, 7'h23}: return 5'b1_1010;
      default:       return 5'b0_0000;
    endcase
  endfunction
  task automatic drive(input logic [1:0] v, input logic [31:0] i0, i1, input logic [4:0] t0, t1, input logic rdy);
    ins_valid = v;
    ins = {i1, i0};
    tag = {t1, t0};
    lsq_ready = rdy;
  endtask
  // advance the reference model by one clock using the currently driven inputs
  task automatic tick();
    logic [4:0] d0, d1;
    logic       rdy;
    d0 = dec(ins[31:0]);
    d1 = dec(ins[63:32]);
    rdy = sb.size() <= 6;
    if (flush) sb.delete();
    else begin
      if (sb.size() != 0 && lsq_ready) void'(sb.pop_front());
      if (rdy) begin
        if (ins_valid[0] && d0[4]) sb.push_back({d0[3:0], ins[31:0], tag[4:0]});
        if (ins_valid[1] && d1[4]) sb.push_back({d1[3:0], ins[63:32], tag[9:5]});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #12;
    n_cmp++; if (lsq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", lsq_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_decode();
    drive(2'b11, mk(3'd2, 7'h03), mk(3'd0, 7'h33), 5'd7, 5'd9, 1'b0);
    #1;
    n_cmp++; if (ls_mask !== 2'b01) begin n_bad++; $display("FAIL lw_add_mask: got %b want 01", ls_mask); end
    tick();
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL lw_count: got %0d want 1", count); end
    n_cmp++; if (lsq_type !== 4'b0010) begin n_bad++; $display("FAIL lw_type: got %b want 0010", lsq_type); end
    n_cmp++; if (lsq_tag !== 5'd7) begin n_bad++; $display("FAIL lw_tag: got %0d want 7", lsq_tag); end
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      lsq_ready = 1; #1;
      n_cmp++; if ({lsq_valid, lsq_type, lsq_ins, lsq_tag} !== {1'b1, sb[0]}) begin n_bad++; $display("FAIL decode_drain: got %b_%h_%h_%h want 1_%h", lsq_valid, lsq_type, lsq_ins, lsq_tag, sb[0]); end
      tick();
    end
  endtask
  task automatic test_compaction();
    drive(2'b11, mk(3'd0, 7'h33), mk(3'd0, 7'h23), 5'd3, 5'd4, 1'b0);
    #1;
    n_cmp++; if (ls_mask !== 2'b10) begin n_bad++; $display("FAIL add_sb_mask: got %b want 10", ls_mask); end
    tick();
    n_cmp++; if (lsq_type !== 4'b1000 || lsq_tag !== 5'd4) begin n_bad++; $display("FAIL sb_head: got %b/%0d want 1000/4", lsq_type, lsq_tag); end
    drive(2'b11, mk(3'd4, 7'h03), mk(3'd5, 7'h03), 5'd5, 5'd6, 1'b0);
    tick();
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL lbu_lhu_count: got %0d want 3", count); end
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      lsq_ready = 1; #1;
      n_cmp++; if ({lsq_valid, lsq_type, lsq_ins, lsq_tag} !== {1'b1, sb[0]}) begin n_bad++; $display("FAIL compact_drain: got %b_%h_%h_%h want 1_%h", lsq_valid, lsq_type, lsq_ins, lsq_tag, sb[0]); end
      tick();
    end
  endtask
  task automatic test_fill_and_wrap();
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, mk(3'd2, 7'h23), mk(3'd1, 7'h23), 5'(2*i+10), 5'(2*i+11), 1'b0);
      #1;
      n_cmp++; if (count !== 4'(sb.size())) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", count, sb.size()); end
      n_cmp++; if (in_ready !== (sb.size() <= 6)) begin n_bad++; $display("FAIL fill_ready: got %b want %b at %0d", in_ready, sb.size() <= 6, sb.size()); end
      if (sb.size() != 0) begin
        n_cmp++; if ({lsq_type, lsq_ins, lsq_tag} !== sb[0]) begin n_bad++; $display("FAIL fill_stable: got %h_%h_%h want %h", lsq_type, lsq_ins, lsq_tag, sb[0]); end
      end
      tick();
    end
    n_cmp++; if (count !== 4'd8 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full: got %0d/%b want 8/0", count, in_ready); end
    drive(2'b00, '0, '0, '0, '0, 1'b1);
    tick();
    n_cmp++; if (count !== 4'd7 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full_deq: got %0d/%b want 7/0", count, in_ready); end
    drive(2'b01, mk(3'd0, 7'h03), '0, 5'd30, '0, 1'b1);
    tick();
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL blocked_enq: got %0d want 6", count); end
    drive(2'b01, mk(3'd1, 7'h03), '0, 5'd31, '0, 1'b1);
    tick();
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL enq_deq_same: got %0d want 6", count); end
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      lsq_ready = 1; #1;
      n_cmp++; if ({lsq_valid, lsq_type, lsq_ins, lsq_tag} !== {1'b1, sb[0]}) begin n_bad++; $display("FAIL wrap_drain: got %b_%h_%h_%h want 1_%h", lsq_valid, lsq_type, lsq_ins, lsq_tag, sb[0]); end
      tick();
    end
    n_cmp++; if (lsq_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: got %b want 0", lsq_valid); end
  endtask
  task automatic test_flush();
    drive(2'b11, mk(3'd0, 7'h03), mk(3'd2, 7'h03), 5'd1, 5'd2, 1'b0);
    tick();
    drive(2'b11, mk(3'd0, 7'h23), mk(3'd1, 7'h23), 5'd3, 5'd4, 1'b0);
    tick();
    drive(2'b01, mk(3'd4, 7'h03), '0, 5'd5, '0, 1'b0);
    tick();
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL pre_flush_count: got %0d want 5", count); end
    drive(2'b11, mk(3'd2, 7'h03), mk(3'd2, 7'h23), 5'd6, 5'd7, 1'b1);
    flush = 1;
    tick();
    flush = 0;
    drive(2'b00, '0, '0, '0, '0, 1'b1);
    #1;
    n_cmp++; if (count !== 4'd0 || lsq_valid !== 1'b0) begin n_bad++; $display("FAIL flush: got %0d/%b want 0/0", count, lsq_valid); end
    tick();
    n_cmp++; if (count !== 4'(sb.size()) || in_ready !== 1'b1) begin n_bad++; $display("FAIL post_flush: got %0d/%b want 0/1", count, in_ready); end
  endtask
  task automatic test_async_reset();
    drive(2'b11, mk(3'd2, 7'h03), mk(3'd2, 7'h23), 5'd8, 5'd9, 1'b0);
    tick();
    #2;
    rst_n = 0;
    #1;
    sb.delete();
    n_cmp++; if (lsq_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin n_bad++; $display("FAIL async_reset: got %b/%b/%0d want 0/1/0", lsq_valid, in_ready, count); end
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    drive(2'b11, mk(3'd1, 7'h03), mk(3'd3, 7'h03), 5'd12, 5'd13, 1'b0);
    #1;
    n_cmp++; if (ls_mask !== 2'b01) begin n_bad++; $display("FAIL lh_mask: got %b want 01", ls_mask); end
    tick();
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd1 || lsq_type !== 4'b0001 || lsq_tag !== 5'd12) begin n_bad++; $display("FAIL lh_head: got %0d/%b/%0d want 1/0001/12", count, lsq_type, lsq_tag); end
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      lsq_ready = 1; #1;
      n_cmp++; if ({lsq_valid, lsq_type, lsq_ins, lsq_tag} !== {1'b1, sb[0]}) begin n_bad++; $display("FAIL reset_drain: got %b_%h_%h_%h want 1_%h", lsq_valid, lsq_type, lsq_ins, lsq_tag, sb[0]); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_compaction();
    test_fill_and_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
